// File: rtl/uart_pkg.sv
// uart_pkg: shared types and sizing helpers for the UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int MaxDataWidth = 9;
    localparam int IdxW = $clog2(MaxDataWidth);

    function automatic int clks_per_bit(int clock_freq, int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_if.sv
// uart_if: valid/ready byte handshake between the TX holding register and uart_tx.
interface uart_if #(
    parameter int DataWidth = 8
);
    logic [DataWidth-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_parity.sv
// uart_parity: parity bit for one frame; constant for mark/space/none.
module uart_parity #(
    parameter int    DataWidth  = 8,
    parameter string ParityType = "none"
) (
    input  logic [DataWidth-1:0] data_i,
    output logic                 parity_o
);
    localparam bit UseData = (ParityType == "even") || (ParityType == "odd");
    localparam bit Invert  = (ParityType == "odd") || (ParityType == "mark");

    assign parity_o = (UseData & (^data_i)) ^ Invert;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: serialises bytes as start, data LSB-first, optional parity, stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int    ClockFreq  = 100_000_000,
    parameter int    BaudRate   = 115200,
    parameter int    DataWidth  = 8,
    parameter string ParityType = "none",
    parameter int    StopBits   = 1
) (
    input  logic clk_i,
    input  logic reset_n_i,
    uart_if.slave bus,
    output logic tx_o,
    output logic busy_o
);
    localparam int ClksPerBit = clks_per_bit(ClockFreq, BaudRate);
    localparam int CntW       = (ClksPerBit < 2) ? 1 : $clog2(ClksPerBit);
    localparam bit HasParity  = (ParityType != "none");
    localparam bit ParityOk   = (ParityType == "none") || (ParityType == "even") ||
                                (ParityType == "odd")  || (ParityType == "mark") ||
                                (ParityType == "space");

    localparam logic [CntW-1:0] CntMax   = CntW'(ClksPerBit - 1);
    localparam logic [IdxW-1:0] LastData = IdxW'(DataWidth - 1);
    localparam logic [IdxW-1:0] LastStop = IdxW'(StopBits - 1);

    if (ClksPerBit < 2) begin : g_bad_cpb
        $error("uart_tx: ClksPerBit must be at least 2");
    end
    if (StopBits != 1 && StopBits != 2) begin : g_bad_stop
        $error("uart_tx: StopBits must be 1 or 2");
    end
    if (!ParityOk) begin : g_bad_parity
        $error("uart_tx: unknown ParityType");
    end
    if (DataWidth < 5 || DataWidth > 9) begin : g_bad_width
        $error("uart_tx: DataWidth must be 5..9");
    end

    tx_state_t            state;
    logic [CntW-1:0]      cnt;
    logic [IdxW-1:0]      idx;
    logic [DataWidth-1:0] shreg;
    logic [DataWidth-1:0] latched;
    logic                 ready;
    logic                 parity;
    logic                 bit_done;

    assign bus.ready = ready;
    assign bit_done  = (cnt == CntMax);

    // Parity works from the untouched copy; shreg is consumed as bits go out.
    uart_parity #(
        .DataWidth (DataWidth),
        .ParityType(ParityType)
    ) u_parity (
        .data_i  (latched),
        .parity_o(parity)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            latched <= '0;
            tx_o    <= 1'b1;
            ready   <= 1'b1;
            busy_o  <= 1'b0;
        end else begin
            cnt <= bit_done ? '0 : cnt + 1'b1;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.valid && ready) begin
                        latched <= bus.data;
                        shreg   <= bus.data;
                        state   <= START;
                        tx_o    <= 1'b0;
                        ready   <= 1'b0;
                        busy_o  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state <= DATA;
                        idx   <= '0;
                        tx_o  <= shreg[0];
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        shreg <= shreg >> 1;
                        if (idx == LastData) begin
                            idx <= '0;
                            if (HasParity) begin
                                state <= PARITY;
                                tx_o  <= parity;
                            end else begin
                                state <= STOP;
                                tx_o  <= 1'b1;
                            end
                        end else begin
                            idx  <= idx + 1'b1;
                            tx_o <= shreg[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        state <= STOP;
                        idx   <= '0;
                        tx_o  <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (idx == LastStop) begin
                            state  <= IDLE;
                            idx    <= '0;
                            ready  <= 1'b1;
                            busy_o <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
